// File: rtl/alu_pkg.sv
// Shared ALU types: serial datapath FSM states and default data width.
// No logic; imported by the serial subtract path and its interface.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ALU_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle of the serial subtractor; master drives operands, slave returns results.
// Pure wiring, no latency; start is honoured only while the slave is idle.
interface serial_subtractor_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, overflow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, overflow
    );

endinterface

// File: rtl/FullSubtractor1Bit.sv
// 1-bit full subtractor: S = A - B - Cin, Cout is the borrow out.
// Purely combinational, no backpressure.
module FullSubtractor1Bit (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Cout,
    output logic S
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (~A & B) | (~A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin through one full-subtractor cell; done WIDTH+1 cycles after start.
// start ignored while busy or done; results hold until the next accepted start.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  io
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_q;
    logic             borrow;
    logic             bout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_borrow;
    logic             last_step;

    assign last_step = (cnt == LAST);

    FullSubtractor1Bit u_cell (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (borrow),
        .Cout (cell_borrow),
        .S    (cell_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.start) state_nxt = SHIFT;
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            borrow <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.start) begin
                        a_sh   <= io.a;
                        b_sh   <= io.b;
                        borrow <= io.bin;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    borrow <= cell_borrow;
                    diff_q <= {cell_d, diff_q[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    // Counter parks on the MSB step so it only ever restarts via a load.
                    if (last_step) begin
                        ovf_q  <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ cell_d);
                        bout_q <= cell_borrow;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.busy     = (state == SHIFT);
    assign io.done     = (state == DONE);
    assign io.diff     = diff_q;
    assign io.bout     = bout_q;
    assign io.overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised and directed checks of serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int a, input int b, input int bin,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int r, sa, sb, sr;
        r  = a - b - bin;
        d  = W'(r);
        bo = (r < 0);
        sa = (a >= 2**(W-1)) ? a - 2**W : a;
        sb = (b >= 2**(W-1)) ? b - 2**W : b;
        sr = sa - sb - bin;
        ov = (sr < -(2**(W-1))) || (sr > 2**(W-1) - 1);
    endfunction

    task automatic run_op(input int a, input int b, input int bin, input int inject_k, input string tag);
        logic [W-1:0] ed;
        logic eb, eo;
        int k, busy_n, done_k, extra;
        model(a, b, bin, ed, eb, eo);
        @(negedge clk);
        bus.start = 1'b1; bus.a = W'(a); bus.b = W'(b); bus.bin = 1'(bin);
        @(negedge clk);
        bus.start = 1'b0;
        k = 1; busy_n = 0; done_k = 0;
        while (done_k == 0 && k <= W + 4) begin
            if (bus.busy) busy_n++;
            if (bus.done) done_k = k;
            if (inject_k > 0 && k == inject_k) begin
                bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0;
            end else if (inject_k > 0 && k == inject_k + 1) begin
                bus.start = 1'b0;
            end
            if (done_k == 0) begin
                @(negedge clk);
                k++;
            end
        end
        check({tag, "_lat"}, done_k, W + 1);
        check({tag, "_busy"}, busy_n, W);
        check({tag, "_diff"}, bus.diff, ed);
        check({tag, "_bout"}, bus.bout, eb);
        check({tag, "_ovf"}, bus.overflow, eo);
        extra = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check({tag, "_nodone"}, extra, 0);
        check({tag, "_hold"}, bus.diff, ed);
    endtask

    int dir_a   [6] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00, 8'hFF};
    int dir_b   [6] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'hFF};
    int dir_bin [6] = '{0, 0, 0, 0, 1, 0};

    initial begin
        logic [W-1:0] ed;
        logic eb, eo;
        int extra, cyc, last_cyc, t, ra, rb, rbin;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_bout", bus.bout, 0);
        check("rst_ovf", bus.overflow, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_op(dir_a[i], dir_b[i], dir_bin[i], 0, $sformatf("dir%0d", i));
        run_op(8'h05, 8'h03, 0, 4, "inject");
        run_op(8'h7F, 8'hFF, 0, 0, "preset");

        // Abort mid-shift with a one-cycle reset.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h22; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_diff", bus.diff, 0);
        check("abort_bout", bus.bout, 0);
        check("abort_ovf", bus.overflow, 0);
        extra = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        check("abort_quiet", extra, 0);
        run_op(8'h55, 8'h22, 1, 0, "post_abort");

        // Back-to-back regression with start held high.
        @(negedge clk);
        ra = $urandom_range(2**W - 1, 0); rb = $urandom_range(2**W - 1, 0); rbin = $urandom_range(1, 0);
        bus.start = 1'b1; bus.a = W'(ra); bus.b = W'(rb); bus.bin = 1'(rbin);
        cyc = 0; last_cyc = 0;
        for (int n = 0; n < 1000; n++) begin
            model(ra, rb, rbin, ed, eb, eo);
            t = 0;
            do begin
                @(negedge clk);
                cyc++; t++;
            end while (!bus.done && t < 3 * W);
            check("rg_done", bus.done, 1);
            check("rg_diff", bus.diff, ed);
            check("rg_bout", bus.bout, eb);
            check("rg_ovf", bus.overflow, eo);
            if (n > 0) check("rg_space", cyc - last_cyc, W + 2);
            last_cyc = cyc;
            ra = $urandom_range(2**W - 1, 0); rb = $urandom_range(2**W - 1, 0); rbin = $urandom_range(1, 0);
            bus.a = W'(ra); bus.b = W'(rb); bus.bin = 1'(rbin);
        end
        bus.start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes A - B - Bin, one bit per clock, through a single 1-bit full-subtractor cell plus a registered borrow.
- Sits directly upstream of the ALU result mux and serves as the area-minimal subtract path.
- Accepts operands on a start pulse, reports busy during computation, and pulses done with the difference, borrow-out and signed overflow.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled with start.
- b  input  WIDTH  subtrahend; sampled with start.
- bin  input  1  borrow-in; sampled with start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse when results become valid.
- diff  output  WIDTH  difference A - B - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 when A < B + bin (unsigned).
- overflow  output  1  two's-complement signed overflow of the subtraction.

Behaviour:
- One clock domain (clk). rst_n is synchronous and active-low: on a clk edge with rst_n=0, state goes to IDLE.
- Reset clears busy, done, diff, bout, overflow, the operand shift registers, the borrow register and the bit counter to 0. This also applies mid-operation: the computation is aborted and no done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Load a into a_sh, b into b_sh, and bin into the borrow register.
  - Clear the counter.
  - Go to SHIFT.
  - diff, bout and overflow keep their previous values until overwritten.
- IDLE, start=0: stay in IDLE.
- SHIFT, each cycle, with cell inputs A=a_sh[0], B=b_sh[0], Cin=borrow:
  - d = A^B^Cin.
  - borrow <= (~A&B) | (~A&Cin) | (B&Cin).
  - diff register shifts right, with d entering at bit WIDTH-1.
  - a_sh and b_sh shift right.
  - Counter increments.
  - When counter == WIDTH-1 (the MSB step):
    - overflow <= (A^B) & (A^d).
    - bout takes the new borrow.
    - Go to DONE.
- DONE:
  - done=1 for exactly this cycle; diff, bout and overflow are valid.
  - Go to IDLE on the next edge.
- busy=1 only in SHIFT. done=1 only in DONE. Both are registered state decodes, with no combinational path from inputs.
- Latency: with start sampled at edge E0, done is high in the cycle after edge E0+WIDTH. That is WIDTH+1 cycles from the start cycle to the done cycle; throughput is one operation per WIDTH+2 cycles.
- start during SHIFT or DONE is ignored; it is neither queued nor allowed to corrupt operands. A start asserted continuously is re-accepted in the first IDLE cycle after DONE.
- Results hold after done until the next accepted start begins shifting. diff is only guaranteed valid from the done cycle until the next start.
- Counter width: $clog2(WIDTH); wraps only through reload on start.
- Arithmetic matches a WIDTH-bit ripple chain of full-subtractor cells with Cin=bin at the LSB.

Decomposition:
- Shared package alu_pkg:
  - State enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Default ALU data width constant ALU_WIDTH=8.
- One sub-module: the existing 1-bit cell FullSubtractor1Bit (ports A, B, Cin, Cout, S), instantiated once for the per-bit combinational step.
- FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start one cycle → busy for 8 cycles; done 9 cycles after the start cycle; diff=0x02, bout=0, overflow=0.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, overflow=0.
- Signed overflow cases:
  - a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, overflow=1.
  - a=0x7F, b=0xFF → diff=0x80, bout=1, overflow=1.
- Borrow-in: a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1, overflow=0. Then a=0xFF, b=0xFF, bin=0 → diff=0x00, bout=0.
- start pulsed with new operands (0x10, 0x01) during cycle 4 of SHIFT → ignored; the first result is unchanged and no second done appears.
- rst_n=0 for one cycle during SHIFT → next cycle: IDLE, busy=0, done=0, diff=0; no done follows. A subsequent start computes correctly.
- Random regression: 1000 operations with random a, b, bin and back-to-back start held high, checked against a reference model (a - b - bin); done spacing is WIDTH+2 cycles.
